// File: rtl/tsense_readout.sv
// tsense_readout: buffers sensor results in a FIFO and serialises each as a framed 16-bit word; TSENSE_RO_AVG_EN averages capture pairs
module tsense_readout #(
    parameter int DEPTH   = 4,
    parameter int CLKDIV  = 4,
    parameter int GAP_CYC = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pwrup,
    input  logic                     valid_i,
    input  logic [7:0]               data_i,
    output logic                     sdo,
    output logic                     sfr,
    output logic                     busy,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKDIV > GAP_CYC ? CLKDIV : GAP_CYC) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t state, state_n;

    logic          valid_q, cap, push_req, push_ok, drop, load, bit_end, gap_end;
    logic [2:0]    seq;
    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [15:0]   sr, frame;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] cnt;
    logic [7:0]    push_data;
    logic [LW-1:0] lvl_after;
    logic [31:0]   lvl_ext;

    assign cap = valid_i & ~valid_q & pwrup;

`ifdef TSENSE_RO_AVG_EN
    logic       pend_v;
    logic [7:0] pend_d;
    logic [8:0] sum;
    assign sum       = {1'b0, pend_d} + {1'b0, data_i} + 9'd1;
    assign push_req  = cap & pend_v;
    assign push_data = 8'(sum >> 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pend_v <= 1'b0;
            pend_d <= '0;
        end else if (!pwrup) begin
            pend_v <= 1'b0;
        end else if (cap) begin
            pend_v <= ~pend_v;
            if (!pend_v) pend_d <= data_i;
        end
`else
    assign push_req  = cap;
    assign push_data = data_i;
`endif

    // A full FIFO still accepts a push when the same cycle pops
    assign push_ok   = push_req & ((level < LW'(DEPTH)) | load);
    assign drop      = push_req & ~push_ok;
    assign lvl_after = level - LW'(1);
    assign lvl_ext   = 32'(lvl_after);
    assign frame     = {1'b1, ovf, mem[rd_ptr], lvl_ext > 32'd7 ? 3'd7 : lvl_ext[2:0]};
    assign sdo       = sr[15];
    assign busy      = state != IDLE;

    always_comb begin
        load    = state == IDLE && pwrup && level != '0;
        bit_end = cnt == CW'(CLKDIV - 1);
        gap_end = cnt == CW'(GAP_CYC - 1);
        state_n = state == IDLE  ? (load ? SHIFT : IDLE) :
                  state == SHIFT ? (bit_end && bit_cnt == 4'd15 ? GAP : SHIFT) :
                                   (gap_end ? IDLE : GAP);
    end

    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= {seq, push_data};

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            seq     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovf     <= 1'b0;
            sr      <= '0;
            sfr     <= 1'b0;
            bit_cnt <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            valid_q <= valid_i;
            ovf     <= drop | (ovf & ~load);
            if (!pwrup) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    seq    <= seq + 1'b1;
                end
                if (load) rd_ptr <= rd_ptr + 1'b1;
                level <= level + LW'(push_ok) - LW'(load);
            end
            // sr shifts in zeros, so sdo is already low once the last bit leaves
            if (load) begin
                sr      <= frame;
                sfr     <= 1'b1;
                cnt     <= '0;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                cnt <= bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    sr      <= sr << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    sfr     <= bit_cnt != 4'd15;
                end
            end else if (state == GAP) begin
                cnt <= gap_end ? '0 : cnt + 1'b1;
            end
        end
endmodule
